stage_c_execute: RTL and testbench

STAGE_C_EXECUTE -- requirements
Module: stage_c_execute

---
 rtl/stage_c_execute_pkg.sv | 20 ++
 rtl/stage_c_execute.sv | 92 +++++++++
 tb/tb_stage_c_execute.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stage_c_execute_pkg.sv
// Shared opcode constants for the pipeline stages: one-hot operation bit indices.
package stage_c_execute_pkg;

    localparam int OPCODE_MSB = 7;

    localparam int OP_RIGHT = 0;
    localparam int OP_LEFT  = 1;
    localparam int OP_INC   = 2;
    localparam int OP_DEC   = 3;
    localparam int OP_IN    = 4;
    localparam int OP_OUT   = 5;
    localparam int OP_JZ    = 6;
    localparam int OP_JNZ   = 7;

    // Ops whose result the write-back stage stores to DRAM at the data pointer.
    function automatic logic is_write_op(input logic [OPCODE_MSB:0] op);
        return op[OP_INC] | op[OP_DEC] | op[OP_IN];
    endfunction

endpackage

// File: rtl/stage_c_execute.sv
// Execute stage: reads the cell at dp (with a one-entry bypass covering the
// write-back DRAM lag), applies INC/DEC/IN, and hands the result to write-back.
module stage_c_execute
    import stage_c_execute_pkg::*;
#(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [A_WIDTH-1:0]   dp,
    output logic [A_WIDTH-1:0]   da,
    input  logic [D_WIDTH-1:0]   dd,
    input  logic [7:0]           cd,
    input  logic                 crda,
    output logic                 cack,
    input  logic [OPCODE_MSB:0]  operation_in,
    output logic                 ack,
    output logic [OPCODE_MSB:0]  operation,
    output logic [D_WIDTH-1:0]   a,
    input  logic                 ack_in
);

    logic [OPCODE_MSB:0] operation_q, operation_d;
    logic [D_WIDTH-1:0]  a_q, a_d;
    logic                byp_vld_q, byp_vld_d;
    logic [A_WIDTH-1:0]  byp_addr_q, byp_addr_d;
    logic [D_WIDTH-1:0]  byp_data_q, byp_data_d;

    logic                ext_wait;
    logic [D_WIDTH-1:0]  operand;
    logic [D_WIDTH-1:0]  result;

    assign da       = dp;
    assign ext_wait = operation_in[OP_IN] && !crda;
    assign ack      = ack_in && !ext_wait;
    assign cack     = ack_in && operation_in[OP_IN] && crda;

    // DRAM still holds the old value for one cycle after a write-type op.
    assign operand = (byp_vld_q && (byp_addr_q == dp)) ? byp_data_q : dd;

    always_comb begin
        result = operand;
        if (operation_in[OP_INC])
            result = operand + 1'b1;
        else if (operation_in[OP_DEC])
            result = operand - 1'b1;
        else if (operation_in[OP_IN])
            result = D_WIDTH'(cd);
    end

    always_comb begin
        operation_d = operation_q;
        a_d         = a_q;
        byp_vld_d   = byp_vld_q;
        byp_addr_d  = byp_addr_q;
        byp_data_d  = byp_data_q;
        if (ack_in) begin
            if (ext_wait) begin
                operation_d = '0;
            end else begin
                operation_d = operation_in;
                a_d         = result;
                if (is_write_op(operation_in)) begin
                    byp_vld_d  = 1'b1;
                    byp_addr_d = dp;
                    byp_data_d = result;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            operation_q <= '0;
            a_q         <= '0;
            byp_vld_q   <= 1'b0;
            byp_addr_q  <= '0;
            byp_data_q  <= '0;
        end else begin
            operation_q <= operation_d;
            a_q         <= a_d;
            byp_vld_q   <= byp_vld_d;
            byp_addr_q  <= byp_addr_d;
            byp_data_q  <= byp_data_d;
        end
    end

    assign operation = operation_q;
    assign a         = a_q;

endmodule

// File: tb/tb_stage_c_execute.sv
// Bench for stage_c_execute: table of per-cycle vectors plus hand sequences,
// registered outputs checked through an expectation queue one cycle later.
module tb_stage_c_execute;
    import stage_c_execute_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;

    localparam logic [7:0] NOP = 8'h00;
    localparam logic [7:0] INC = 8'(1 << OP_INC);
    localparam logic [7:0] DEC = 8'(1 << OP_DEC);
    localparam logic [7:0] INP = 8'(1 << OP_IN);
    localparam logic [7:0] OUT = 8'(1 << OP_OUT);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] dp = '0;
    logic [AW-1:0] da;
    logic [DW-1:0] dd = '0;
    logic [7:0]    cd = '0;
    logic          crda = 1'b0;
    logic          cack;
    logic [7:0]    operation_in = '0;
    logic          ack;
    logic [7:0]    operation;
    logic [DW-1:0] a;
    logic          ack_in = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          rst;
        logic          ack_in;
        logic [AW-1:0] dp;
        logic [DW-1:0] dd;
        logic [7:0]    op;
        logic          crda;
        logic [7:0]    cd;
        logic          e_ack;
        logic          e_cack;
        logic [7:0]    e_op;
        logic [DW-1:0] e_a;
    } vec_t;

    typedef struct {
        logic [7:0]    op;
        logic [DW-1:0] a;
    } exp_t;

    exp_t exp_q[$];

    stage_c_execute #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .dp(dp), .da(da), .dd(dd), .cd(cd),
        .crda(crda), .cack(cack), .operation_in(operation_in), .ack(ack),
        .operation(operation), .a(a), .ack_in(ack_in)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic ain, input int p,
                                input int d, input logic [7:0] op, input logic rd,
                                input int c, input logic eack, input logic ecack,
                                input logic [7:0] eop, input int ea);
        vec_t v;
        v.rst = rst; v.ack_in = ain; v.dp = AW'(p); v.dd = DW'(d); v.op = op;
        v.crda = rd; v.cd = 8'(c); v.e_ack = eack; v.e_cack = ecack;
        v.e_op = eop; v.e_a = DW'(ea);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset = v.rst; ack_in = v.ack_in; dp = v.dp; dd = v.dd;
        operation_in = v.op; crda = v.crda; cd = v.cd;
        #1;
        chk("ack", 32'(ack), 32'(v.e_ack));
        chk("cack", 32'(cack), 32'(v.e_cack));
        chk("da", 32'(da), 32'(v.dp));
        exp_q.push_back('{op: v.e_op, a: v.e_a});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("operation", 32'(operation), 32'(e.op));
            chk("a", 32'(a), 32'(e.a));
        end
    endtask

    vec_t tbl[$];

    initial begin
        //            rst ain  dp  dd    op   crda cd    ack cack eop  ea
        tbl.push_back(mk(1, 0,  0, 8'h00, NOP, 0, 8'h00, 0, 0, NOP, 8'h00));
        tbl.push_back(mk(1, 1,  0, 8'h00, NOP, 0, 8'h00, 1, 0, NOP, 8'h00));
        tbl.push_back(mk(0, 1,  5, 8'h10, INC, 0, 8'h00, 1, 0, INC, 8'h11));
        tbl.push_back(mk(0, 1,  6, 8'h00, DEC, 0, 8'h00, 1, 0, DEC, 8'hFF));
        tbl.push_back(mk(0, 1,  8, 8'hFF, INC, 0, 8'h00, 1, 0, INC, 8'h00));
        tbl.push_back(mk(0, 1,  9, 8'h33, OUT, 0, 8'h00, 1, 0, OUT, 8'h33));
        tbl.push_back(mk(0, 1,  9, 8'h44, NOP, 0, 8'h00, 1, 0, NOP, 8'h44));
        tbl.push_back(mk(0, 1, 10, 8'h55, INP, 1, 8'h5A, 1, 1, INP, 8'h5A));
        // dd at dp=10 still stale; bypass supplies the IN result
        tbl.push_back(mk(0, 1, 10, 8'h00, OUT, 0, 8'h00, 1, 0, OUT, 8'h5A));
        tbl.push_back(mk(0, 1,  7, 8'h20, INC, 0, 8'h00, 1, 0, INC, 8'h21));
        tbl.push_back(mk(0, 1,  7, 8'h20, INC, 0, 8'h00, 1, 0, INC, 8'h22));
        tbl.push_back(mk(0, 1,  7, 8'h22, DEC, 0, 8'h00, 1, 0, DEC, 8'h21));
        foreach (tbl[i]) step(tbl[i]);

        // EXT wait: three bubbles, then consume 0x41
        for (int i = 0; i < 3; i++)
            step(mk(0, 1, 11, 8'h00, INP, 0, 8'h00, 0, 0, NOP, 8'h21));
        step(mk(0, 1, 11, 8'h00, INP, 1, 8'h41, 1, 1, INP, 8'h41));

        // Downstream stall: everything held, then normal acceptance
        for (int i = 0; i < 2; i++)
            step(mk(0, 0, 3, 8'h30, INC, 0, 8'h00, 0, 0, INP, 8'h41));
        step(mk(0, 0, 3, 8'h30, INP, 0, 8'h00, 0, 0, INP, 8'h41));
        step(mk(0, 1, 3, 8'h30, INC, 0, 8'h00, 1, 0, INC, 8'h31));

        // Reset during EXT wait clears state and bypass (was dp=3 -> 0x31)
        step(mk(0, 1, 3, 8'h30, INP, 0, 8'h00, 0, 0, NOP, 8'h31));
        step(mk(1, 1, 3, 8'h30, INP, 0, 8'h00, 0, 0, NOP, 8'h00));
        step(mk(0, 1, 3, 8'h50, INC, 0, 8'h00, 1, 0, INC, 8'h51));

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
